key_event: RTL and testbench
============================

# key_event

Turns the debounced, active-low key level from the `inkey` debouncer into one-cycle event pulses: short press, double click, long press and auto-repeat while held. It sits directly downstream of `inkey`, in the same clock domain, and feeds control logic that wants discrete key events rather than levels. All timing is expressed in clock cycles, so the block is independent of clock frequency.

## Interface
Parameters:
- `LONG_CYCLES`, default 50_000_000: hold time, in cycles, before `long_press` fires; must be ≥ 2.
- `GAP_CYCLES`, default 12_500_000: maximum release-to-press gap, in cycles, for a double click; must be ≥ 2.
- `REPEAT_CYCLES`, default 10_000_000: period of `repeat` pulses after `long_press`; 0 disables repeat.

Ports:
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: **synchronous, active-high reset**.
- `key_n` in 1: debounced key level from `inkey` `out`; 0 = pressed, 1 = released.
- `pressed` out 1: registered level, `~key_n` delayed by one cycle.
- `short_press` out 1: one-cycle pulse.
- `double_click` out 1: one-cycle pulse.
- `long_press` out 1: one-cycle pulse.
- `repeat` out 1: one-cycle pulse.

## Operation
- Input stage:
  - `key_r` samples `key_n` every edge.
  - The FSM acts only on `key_r`.
  - `pressed = ~key_r`.
- FSM states: IDLE, PRESS1, GAP, PRESS2, HELD.
- Counter `cnt` is `$clog2(max(LONG,GAP,REPEAT)+1)` bits, unsigned, saturating. It is cleared to 1 on every state change.
- IDLE:
  - If pressed: go to PRESS1.
- PRESS1:
  - If pressed and `cnt == LONG_CYCLES-1`: pulse `long_press`, go to HELD.
  - Else if pressed: increment `cnt`.
  - If released: go to GAP.
- GAP:
  - If pressed: pulse `double_click`, go to PRESS2.
  - Else if `cnt == GAP_CYCLES-1`: pulse `short_press`, go to IDLE.
  - Else: increment `cnt`.
  - A press takes precedence over expiry on the same edge.
- PRESS2:
  - If released: go to IDLE.
  - The second press never produces a `long_press` or `repeat`.
- HELD:
  - If released: go to IDLE.
  - Else if `REPEAT_CYCLES != 0` and `cnt == REPEAT_CYCLES`: pulse `repeat`, set `cnt` to 1.
  - Else: increment `cnt`.
  - Releasing after a long press produces no `short_press`.
- Every event output is registered and is high for exactly one cycle. At most one event output is high in any cycle.

## Timing
- Reset values:
  - `key_r` = 1, FSM = IDLE, `cnt` = 0.
  - All outputs are 0, including `pressed`.
- Reset asserted mid-operation: the next edge forces the reset values and discards any pending event.
- A key held through reset is released from reset as `key_r = 1`. It is then detected as a new press, two edges after reset deasserts.
- Let t0 be the edge at which `key_n = 0` is first sampled:
  - `pressed` is high from t0.
  - The FSM enters PRESS1 at t0+1.
  - `long_press` is high in the cycle after edge t0+`LONG_CYCLES`, if the key was held throughout.
- Let t1 be the release sample edge:
  - GAP is entered at t1+1.
  - If no press is sampled, `short_press` is high after edge t1+`GAP_CYCLES`.
- Let t2 be the second press sample edge:
  - A double click requires t2 ≤ t1+`GAP_CYCLES`-1.
  - `double_click` is high after edge t2+1.
- `repeat` pulses arrive every `REPEAT_CYCLES` cycles. The first comes `REPEAT_CYCLES` edges after the `long_press` edge.
- Press latency to the first visible event is 2 edges for `double_click`. A single click is reported only after the gap window closes.

## Structure
- Package `key_event_pkg` holds:
  - the `state_t` enum (IDLE, PRESS1, GAP, PRESS2, HELD);
  - a `max3` constant function used for the counter width.
- Single module, no sub-module. The input register and pulse registers are inline.

## Test plan
All scenarios use parameters `LONG_CYCLES`=20, `GAP_CYCLES`=10, `REPEAT_CYCLES`=5.
- **Short press:** press for 5 cycles, then release and hold released → `short_press` is high exactly once, 10 cycles after the release is sampled; no other pulses.
- **Double click:** press 4, release 6, press 4, release → one `double_click` 2 cycles after the second press; no `short_press`.
- **Gap boundary:**
  - Second press sampled at t1+9 → `double_click`.
  - Second press at t1+10 → `short_press`, then a new PRESS1 sequence starts.
- **Long press and repeat:** hold for 42 cycles, then release →
  - `long_press` after edge t0+20;
  - `repeat` after t0+25, t0+30, t0+35 and t0+40;
  - no `short_press` after release.
- **Repeat disabled:** with `REPEAT_CYCLES`=0, hold for 60 cycles → exactly one `long_press` and zero `repeat`.
- **Reset mid-hold:** hold for 15 cycles, assert `rst` for 1 cycle while still holding →
  - all outputs 0 on the next edge;
  - the press is re-detected;
  - `long_press` arrives 20 edges after the post-reset press sample.

Source files
------------

// File: rtl/key_event_pkg.sv
// Shared types and helpers for the key event decoder.
// Holds the FSM state encoding and the counter-width helper.
package key_event_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    GAP,
    PRESS2,
    HELD
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_event.sv
// Converts the debounced active-low key level into one-cycle key events:
// short press, double click, long press and auto-repeat while held.
module key_event
  import key_event_pkg::*;
#(
  parameter int LONG_CYCLES   = 50_000_000,
  parameter int GAP_CYCLES    = 12_500_000,
  parameter int REPEAT_CYCLES = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pressed,
  output logic short_press,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int CNT_TOP = max3(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES);
  localparam int CW      = $clog2(CNT_TOP + 1);

  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_CYCLES);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  state_t        state;
  logic          key_r;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;

  // Saturating increment so an idle counter can never wrap into a match.
  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_ONE;
  assign pressed = ~key_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_r        <= 1'b1;
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
    end else begin
      key_r        <= key_n;
      short_press  <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      repeat_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (!key_r) begin
            state <= PRESS1;
            cnt   <= CNT_ONE;
          end
        end
        PRESS1: begin
          if (key_r) begin
            state <= GAP;
            cnt   <= CNT_ONE;
          end else if (cnt == LONG_LAST) begin
            long_press <= 1'b1;
            state      <= HELD;
            cnt        <= CNT_ONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        GAP: begin
          // A press on the closing edge still counts as a double click.
          if (!key_r) begin
            double_click <= 1'b1;
            state        <= PRESS2;
            cnt          <= CNT_ONE;
          end else if (cnt == GAP_LAST) begin
            short_press <= 1'b1;
            state       <= IDLE;
            cnt         <= CNT_ONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        PRESS2: begin
          if (key_r) begin
            state <= IDLE;
            cnt   <= CNT_ONE;
          end
        end
        HELD: begin
          if (key_r) begin
            state <= IDLE;
            cnt   <= CNT_ONE;
          end else if ((REPEAT_CYCLES != 0) && (cnt == RPT_LAST)) begin
            repeat_pulse <= 1'b1;
            cnt          <= CNT_ONE;
          end else begin
            cnt <= cnt_inc;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= CNT_ONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event: short/double/long/repeat events, the gap
// boundary, disabled repeat and reset during a hold.
module tb_key_event;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key_n = 1'b1;

  logic pressed, short_press, double_click, long_press, repeat_pulse;
  logic pressed0, short0, double0, long0_o, rpt0_o;

  int tests_run = 0;
  int tests_failed = 0;

  // Edge index since last clear, and per-event hit counts / hit edges.
  // Event index: 0 short, 1 double, 2 long, 3 repeat.
  int e;
  int ev_cnt[4];
  int ev_pos[4][8];
  int multi;
  int long0;
  int rpt0;

  always #5 clk = ~clk;

  key_event #(.LONG_CYCLES(20), .GAP_CYCLES(10), .REPEAT_CYCLES(5)) dut (
    .clk(clk), .rst(rst), .key_n(key_n), .pressed(pressed),
    .short_press(short_press), .double_click(double_click),
    .long_press(long_press), .repeat_pulse(repeat_pulse)
  );

  key_event #(.LONG_CYCLES(20), .GAP_CYCLES(10), .REPEAT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .key_n(key_n), .pressed(pressed0),
    .short_press(short0), .double_click(double0),
    .long_press(long0_o), .repeat_pulse(rpt0_o)
  );

  task automatic clear_rec();
    e = 0;
    long0 = 0;
    rpt0 = 0;
    for (int i = 0; i < 4; i++) begin
      ev_cnt[i] = 0;
      for (int j = 0; j < 8; j++) ev_pos[i][j] = -1;
    end
  endtask

  task automatic step(input logic k);
    logic [3:0] ev;
    key_n = k;
    @(posedge clk);
    #1;
    e++;
    ev = {repeat_pulse, long_press, double_click, short_press};
    for (int i = 0; i < 4; i++) begin
      if (ev[i]) begin
        if (ev_cnt[i] < 8) ev_pos[i][ev_cnt[i]] = e;
        ev_cnt[i]++;
      end
    end
    if ($countones(ev) > 1) multi++;
    if (long0_o) long0++;
    if (rpt0_o) rpt0++;
  endtask

  task automatic run(input logic k, input int n);
    for (int i = 0; i < n; i++) step(k);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_rec();
    run(1'b0, 2);
    tests_run++;
    if (pressed !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_pressed got %b want 0", pressed);
    end
    tests_run++;
    if (short_press !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_short got %b want 0", short_press);
    end
    tests_run++;
    if (double_click !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_double got %b want 0", double_click);
    end
    tests_run++;
    if (long_press !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_long got %b want 0", long_press);
    end
    tests_run++;
    if (repeat_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_repeat got %b want 0", repeat_pulse);
    end
    rst = 1'b0;
    run(1'b1, 3);
    $display("[TB] test_reset done");
  endtask

  task automatic test_short_press();
    clear_rec();
    step(1'b0);
    tests_run++;
    if (pressed !== 1'b1) begin
      tests_failed++;
      $display("FAIL short_pressed_level got %b want 1", pressed);
    end
    run(1'b0, 4);
    run(1'b1, 20);
    tests_run++;
    if (pressed !== 1'b0) begin
      tests_failed++;
      $display("FAIL short_released_level got %b want 0", pressed);
    end
    tests_run++;
    if (ev_cnt[0] !== 1) begin
      tests_failed++;
      $display("FAIL short_count got %0d want 1", ev_cnt[0]);
    end
    tests_run++;
    if (ev_pos[0][0] !== 16) begin
      tests_failed++;
      $display("FAIL short_edge got %0d want 16", ev_pos[0][0]);
    end
    tests_run++;
    if (ev_cnt[1] + ev_cnt[2] + ev_cnt[3] !== 0) begin
      tests_failed++;
      $display("FAIL short_others got %0d want 0", ev_cnt[1] + ev_cnt[2] + ev_cnt[3]);
    end
    $display("[TB] test_short_press done");
  endtask

  task automatic test_double_click();
    clear_rec();
    run(1'b0, 4);
    run(1'b1, 6);
    run(1'b0, 4);
    run(1'b1, 15);
    tests_run++;
    if (ev_cnt[1] !== 1) begin
      tests_failed++;
      $display("FAIL double_count got %0d want 1", ev_cnt[1]);
    end
    tests_run++;
    if (ev_pos[1][0] !== 12) begin
      tests_failed++;
      $display("FAIL double_edge got %0d want 12", ev_pos[1][0]);
    end
    tests_run++;
    if (ev_cnt[0] + ev_cnt[2] + ev_cnt[3] !== 0) begin
      tests_failed++;
      $display("FAIL double_others got %0d want 0", ev_cnt[0] + ev_cnt[2] + ev_cnt[3]);
    end
    $display("[TB] test_double_click done");
  endtask

  task automatic test_gap_boundary();
    // Release sampled at edge 4, second press at edge 13 (t1+9).
    clear_rec();
    run(1'b0, 3);
    run(1'b1, 9);
    run(1'b0, 3);
    run(1'b1, 15);
    tests_run++;
    if (ev_cnt[1] !== 1 || ev_pos[1][0] !== 14) begin
      tests_failed++;
      $display("FAIL gap_inside_double got count %0d edge %0d want count 1 edge 14",
               ev_cnt[1], ev_pos[1][0]);
    end
    tests_run++;
    if (ev_cnt[0] !== 0) begin
      tests_failed++;
      $display("FAIL gap_inside_short got %0d want 0", ev_cnt[0]);
    end
    // Second press at edge 14 (t1+10) closes the window, then starts anew.
    clear_rec();
    run(1'b0, 3);
    run(1'b1, 10);
    run(1'b0, 3);
    run(1'b1, 20);
    tests_run++;
    if (ev_cnt[0] !== 2) begin
      tests_failed++;
      $display("FAIL gap_edge_short_count got %0d want 2", ev_cnt[0]);
    end
    tests_run++;
    if (ev_pos[0][0] !== 14) begin
      tests_failed++;
      $display("FAIL gap_edge_short_first got %0d want 14", ev_pos[0][0]);
    end
    tests_run++;
    if (ev_pos[0][1] !== 27) begin
      tests_failed++;
      $display("FAIL gap_edge_short_second got %0d want 27", ev_pos[0][1]);
    end
    tests_run++;
    if (ev_cnt[1] !== 0) begin
      tests_failed++;
      $display("FAIL gap_edge_double got %0d want 0", ev_cnt[1]);
    end
    $display("[TB] test_gap_boundary done");
  endtask

  task automatic test_long_repeat();
    int exp_r[4];
    exp_r = '{26, 31, 36, 41};
    clear_rec();
    run(1'b0, 42);
    run(1'b1, 15);
    tests_run++;
    if (ev_cnt[2] !== 1 || ev_pos[2][0] !== 21) begin
      tests_failed++;
      $display("FAIL long_edge got count %0d edge %0d want count 1 edge 21",
               ev_cnt[2], ev_pos[2][0]);
    end
    tests_run++;
    if (ev_cnt[3] !== 4) begin
      tests_failed++;
      $display("FAIL repeat_count got %0d want 4", ev_cnt[3]);
    end
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (ev_pos[3][i] !== exp_r[i]) begin
        tests_failed++;
        $display("FAIL repeat_edge_%0d got %0d want %0d", i, ev_pos[3][i], exp_r[i]);
      end
    end
    tests_run++;
    if (ev_cnt[0] + ev_cnt[1] !== 0) begin
      tests_failed++;
      $display("FAIL long_release_others got %0d want 0", ev_cnt[0] + ev_cnt[1]);
    end
    $display("[TB] test_long_repeat done");
  endtask

  task automatic test_repeat_disabled();
    clear_rec();
    run(1'b0, 60);
    run(1'b1, 15);
    tests_run++;
    if (long0 !== 1) begin
      tests_failed++;
      $display("FAIL norepeat_long got %0d want 1", long0);
    end
    tests_run++;
    if (rpt0 !== 0) begin
      tests_failed++;
      $display("FAIL norepeat_repeat got %0d want 0", rpt0);
    end
    $display("[TB] test_repeat_disabled done");
  endtask

  task automatic test_reset_mid_hold();
    logic [4:0] outs;
    clear_rec();
    run(1'b0, 15);
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    outs = {pressed, short_press, double_click, long_press, repeat_pulse};
    tests_run++;
    if (outs !== 5'b0) begin
      tests_failed++;
      $display("FAIL midreset_outputs got %b want 00000", outs);
    end
    step(1'b0);
    tests_run++;
    if (pressed !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_repress got %b want 1", pressed);
    end
    run(1'b0, 24);
    run(1'b1, 15);
    tests_run++;
    if (ev_cnt[2] !== 1 || ev_pos[2][0] !== 37) begin
      tests_failed++;
      $display("FAIL midreset_long got count %0d edge %0d want count 1 edge 37",
               ev_cnt[2], ev_pos[2][0]);
    end
    tests_run++;
    if (ev_cnt[0] + ev_cnt[1] !== 0) begin
      tests_failed++;
      $display("FAIL midreset_others got %0d want 0", ev_cnt[0] + ev_cnt[1]);
    end
    $display("[TB] test_reset_mid_hold done");
  endtask

  initial begin
    multi = 0;
    test_reset();
    test_short_press();
    test_double_click();
    test_gap_boundary();
    test_long_repeat();
    test_repeat_disabled();
    test_reset_mid_hold();
    tests_run++;
    if (multi !== 0) begin
      tests_failed++;
      $display("FAIL one_hot_events got %0d overlapping cycles want 0", multi);
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
